cp0_reg: RTL and testbench

- Coprocessor-0 register file for the OpenMIPS core.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Applies exception side-effects for the exception code committed from the MEM stage, in the same cycle the pipeline controller flushes.
- Drives EPC to the pipeline controller as the eret return target, and Status/Cause to MEM for interrupt qualification.
- Owns the Count/Compare timer interrupt.

---
 rtl/cp0_reg_pkg.sv | 61 ++++++
 rtl/cp0_reg_if.sv | 13 +
 rtl/cp0_timer.sv | 49 ++++
 rtl/cp0_reg.sv | 113 +++++++++++
 tb/tb_cp0_reg.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_reg_pkg.sv
// rtl/cp0_reg_pkg.sv - shared CP0 register numbers, exception codes and field positions
// Purpose: constants and small decode helpers used by cp0_reg and cp0_timer.
// Ports: none (package).
package cp0_reg_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  // Committed exception codes as decoded by the pipeline controller
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  // Cause.ExcCode field values
  typedef enum logic [4:0] {
    EXCCODE_INT  = 5'h00,
    EXCCODE_SYS  = 5'h08,
    EXCCODE_RI   = 5'h0a,
    EXCCODE_OV   = 5'h0c,
    EXCCODE_TR   = 5'h0d
  } exccode_e;

  // Status / Cause bit positions
  localparam int STATUS_EXL     = 1;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_WP       = 23;
  localparam int CAUSE_IV       = 22;
  localparam int CAUSE_IP_HI    = 15;
  localparam int CAUSE_IP_LO    = 10;
  localparam int CAUSE_IPSW_HI  = 9;
  localparam int CAUSE_IPSW_LO  = 8;
  localparam int CAUSE_EXC_HI   = 6;
  localparam int CAUSE_EXC_LO   = 2;

  // Codes that record EPC/BD and raise EXL
  function automatic logic is_common_exc(input logic [31:0] code);
    return (code == EXC_INTERRUPT) || (code == EXC_SYSCALL) ||
           (code == EXC_INST_INV)  || (code == EXC_OVERFLOW) ||
           (code == EXC_TRAP);
  endfunction

  function automatic exccode_e exc_code_of(input logic [31:0] code);
    case (code)
      EXC_SYSCALL:  return EXCCODE_SYS;
      EXC_INST_INV: return EXCCODE_RI;
      EXC_OVERFLOW: return EXCCODE_OV;
      EXC_TRAP:     return EXCCODE_TR;
      default:      return EXCCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// rtl/cp0_reg_if.sv - mtc0/mfc0 register access bus
// Purpose: groups the write port (from WB) and read port (from EX) of the CP0 file.
// Signals: we_i, waddr_i, data_i (write); raddr_i, data_o (read).
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, waddr_i, raddr_i, data_i, input data_o);
  modport slave  (input we_i, waddr_i, raddr_i, data_i, output data_o);
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with sticky timer interrupt
// Purpose: free-running Count, Compare register and timer interrupt request.
// Ports: clk, rst (sync active-high); count_we/compare_we/wdata load the registers;
//        count_o, compare_o mirrors; timer_int_o interrupt request.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    count_d     = count_we ? wdata : count_q + 32'd1;
    compare_d   = compare_we ? wdata : compare_q;
    timer_int_d = timer_int_q;
    // Match uses the pre-increment Count; the request is sticky until
    // software rewrites Compare, which also acknowledges it.
    if (compare_we) begin
      timer_int_d = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - OpenMIPS coprocessor-0 register file
// Purpose: Status/Cause/EPC/PRId/Config plus timer, mtc0 writes, mfc0 reads and
//          exception side-effects for the code committed from MEM.
// Ports: clk, rst (sync active-high); bus (mtc0/mfc0 access); int_i hardware
//        interrupts; excepttype_i/current_inst_addr_i/is_in_delayslot_i exception
//        commit; *_o register mirrors; timer_int_o timer interrupt request.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] CONFIG_RST = 32'h00008000,
  parameter logic [31:0] STATUS_RST = 32'h10000000
) (
  input  logic              clk,
  input  logic              rst,
  cp0_reg_if.slave          bus,
  input  logic [5:0]        int_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       current_inst_addr_i,
  input  logic              is_in_delayslot_i,
  output logic [31:0]       count_o,
  output logic [31:0]       compare_o,
  output logic [31:0]       status_o,
  output logic [31:0]       cause_o,
  output logic [31:0]       epc_o,
  output logic [31:0]       config_o,
  output logic [31:0]       prid_o,
  output logic              timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_we    (bus.we_i && (bus.waddr_i == REG_COUNT)),
    .compare_we  (bus.we_i && (bus.waddr_i == REG_COMPARE)),
    .wdata       (bus.data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    cause_d[CAUSE_IP_HI:CAUSE_IP_LO] = int_i;

    if (bus.we_i) begin
      case (bus.waddr_i)
        REG_STATUS: status_d = bus.data_i;
        REG_CAUSE: begin
          // Only the software interrupt bits and IV/WP are writable
          cause_d[CAUSE_IPSW_HI:CAUSE_IPSW_LO] = bus.data_i[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
          cause_d[CAUSE_IV] = bus.data_i[CAUSE_IV];
          cause_d[CAUSE_WP] = bus.data_i[CAUSE_WP];
        end
        REG_EPC: epc_d = bus.data_i;
        default: ;
      endcase
    end

    // Exception handling comes second so it overrides a same-cycle mtc0
    if (is_common_exc(excepttype_i)) begin
      // Nested exceptions keep the original return point
      if (!status_q[STATUS_EXL]) begin
        epc_d = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_of(excepttype_i);
    end else if (excepttype_i == EXC_ERET) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // mfc0 sees committed state only; EX forwarding covers write-then-read
  always_comb begin
    case (bus.raddr_i)
      REG_COUNT:   bus.data_o = count_o;
      REG_COMPARE: bus.data_o = compare_o;
      REG_STATUS:  bus.data_o = status_q;
      REG_CAUSE:   bus.data_o = cause_q;
      REG_EPC:     bus.data_o = epc_q;
      REG_PRID:    bus.data_o = PRID_VAL;
      REG_CONFIG:  bus.data_o = CONFIG_RST;
      default:     bus.data_o = 32'd0;
    endcase
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_RST;
  assign prid_o   = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// tb/tb_cp0_reg.sv - scoreboard bench for cp0_reg
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_COUNT = 0, S_COMPARE = 1, S_STATUS = 2, S_CAUSE = 3, S_EPC = 4,
                 S_CONFIG = 5, S_PRID = 6, S_DATA = 7, S_TINT = 8;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] get_act(input int sel);
    case (sel)
      S_COUNT:   return count_o;
      S_COMPARE: return compare_o;
      S_STATUS:  return status_o;
      S_CAUSE:   return cause_o;
      S_EPC:     return epc_o;
      S_CONFIG:  return config_o;
      S_PRID:    return prid_o;
      S_DATA:    return bus.data_o;
      default:   return {31'd0, timer_int_o};
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle, away from the active edge
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] act;
        act = get_act(sb[i].sel);
        n_checks++;
        if (sb[i].due == cyc && act === sb[i].exp)
          n_pass++;
        else
          $display("FAIL %s: got %h expected %h (due %0d now %0d)",
                   sb[i].name, act, sb[i].exp, sb[i].due, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.due = cyc; e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
    step(1);
    bus.we_i = 1'b0;
  endtask

  task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds);
    excepttype_i = code; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    step(1);
    excepttype_i = 32'd0; is_in_delayslot_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
    is_in_delayslot_i = 1'b0;
    bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.raddr_i = 5'd0; bus.data_i = 32'd0;
    step(2);
    rst = 1'b0;
    chk(S_COUNT, 32'd0, "rst_count");
    chk(S_COMPARE, 32'd0, "rst_compare");
    chk(S_STATUS, 32'h10000000, "rst_status");
    chk(S_CAUSE, 32'd0, "rst_cause");
    chk(S_EPC, 32'd0, "rst_epc");
    chk(S_TINT, 32'd0, "rst_tint");

    step(10);
    bus.raddr_i = 5'd15;
    chk(S_COUNT, 32'd10, "idle_count");
    chk(S_STATUS, 32'h10000000, "idle_status");
    chk(S_CONFIG, 32'h00008000, "idle_config");
    chk(S_DATA, 32'h004C0102, "read_prid");
    chk(S_TINT, 32'd0, "idle_tint");

    // Timer
    wr(5'd11, 32'd20);
    chk(S_COMPARE, 32'd20, "compare_wr");
    chk(S_COUNT, 32'd11, "count_after_wr");
    step(9);
    chk(S_COUNT, 32'd20, "count_at_match");
    chk(S_TINT, 32'd0, "tint_before");
    step(1);
    chk(S_TINT, 32'd1, "tint_rise");
    step(3);
    chk(S_TINT, 32'd1, "tint_hold");
    wr(5'd11, 32'd100);
    chk(S_TINT, 32'd0, "tint_ack");
    chk(S_COMPARE, 32'd100, "compare_100");

    // Syscall, EXL=0
    exc(32'h08, 32'h1000, 1'b0);
    chk(S_EPC, 32'h1000, "sys_epc");
    chk(S_CAUSE, 32'h00000020, "sys_cause");
    chk(S_STATUS, 32'h10000002, "sys_status");

    exc(32'h0e, 32'h0, 1'b0);
    chk(S_STATUS, 32'h10000000, "eret_status");
    chk(S_EPC, 32'h1000, "eret_epc");

    // Overflow in delay slot, then nested trap
    exc(32'h0c, 32'h2004, 1'b1);
    chk(S_EPC, 32'h2000, "ov_epc");
    chk(S_CAUSE, 32'h80000030, "ov_cause");
    chk(S_STATUS, 32'h10000002, "ov_status");
    exc(32'h0d, 32'h3000, 1'b0);
    chk(S_EPC, 32'h2000, "nested_epc");
    chk(S_CAUSE, 32'h80000034, "nested_cause");

    exc(32'h0e, 32'h0, 1'b0);
    chk(S_STATUS, 32'h10000000, "eret2_status");

    // Simultaneous mtc0 EPC and syscall
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'h500;
    exc(32'h08, 32'h600, 1'b0);
    bus.we_i = 1'b0;
    bus.raddr_i = 5'd14;
    chk(S_EPC, 32'h600, "simul_epc");
    chk(S_DATA, 32'h600, "read_epc");
    chk(S_CAUSE, 32'h00000020, "simul_cause");

    // Unknown nonzero code changes nothing
    exc(32'h05, 32'h900, 1'b1);
    chk(S_EPC, 32'h600, "unk_epc");
    chk(S_STATUS, 32'h10000002, "unk_status");

    // Hardware interrupt sampling
    int_i = 6'b000101;
    step(1);
    int_i = 6'd0;
    chk(S_CAUSE, 32'h00001420, "cause_ip");

    wr(5'd13, 32'hFFFFFFFF);
    bus.raddr_i = 5'd13;
    chk(S_CAUSE, 32'h00C00320, "cause_wr_mask");
    chk(S_DATA, 32'h00C00320, "read_cause");

    // Ignored writes to PRId/Config
    wr(5'd15, 32'h0);
    wr(5'd16, 32'h0);
    bus.raddr_i = 5'd16;
    chk(S_DATA, 32'h00008000, "config_ro");
    chk(S_PRID, 32'h004C0102, "prid_ro");

    wr(5'd12, 32'h0000FF01);
    bus.raddr_i = 5'd12;
    chk(S_DATA, 32'h0000FF01, "status_wr");

    // Interrupt exception, ExcCode 0
    exc(32'h01, 32'h700, 1'b0);
    chk(S_EPC, 32'h700, "int_epc");
    chk(S_CAUSE, 32'h00C00300, "int_cause");
    chk(S_STATUS, 32'h0000FF03, "int_status");

    // Count write and wrap
    wr(5'd9, 32'hFFFFFFFF);
    bus.raddr_i = 5'd9;
    chk(S_DATA, 32'hFFFFFFFF, "count_wr");
    step(1);
    chk(S_COUNT, 32'd0, "count_wrap");

    bus.raddr_i = 5'd3;
    chk(S_DATA, 32'd0, "read_unmapped");

    // Reset mid-run
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk(S_COUNT, 32'd0, "rst2_count");
    chk(S_COMPARE, 32'd0, "rst2_compare");
    chk(S_STATUS, 32'h10000000, "rst2_status");
    chk(S_CAUSE, 32'd0, "rst2_cause");
    chk(S_EPC, 32'd0, "rst2_epc");
    chk(S_TINT, 32'd0, "rst2_tint");

    step(2);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      n_checks += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
